mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Memory-access stage directly downstream of the execute stage in the 5-stage MIPS pipeline.
- Takes the execute stage's register-write results plus a load/store descriptor, performs at most one data-bus transaction, and hands the final write-back data to the WB stage.
- Every access is a multi-cycle request/response on the SoC data bus. The stage stalls upstream through in_ready while a transaction is in flight.

Parameters:
- DATA_W, 32, data path and address width; only 32 is supported.
- REG_ADDR_W, 5, register-file address width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  execute-stage result valid.
- in_ready  out  1  stage can accept; high only in IDLE.
- mem_op_i  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; codes 9-15 are treated as NONE.
- mem_addr_i  in  32  effective address.
- mem_store_data_i  in  32  store data, right-aligned.
- reg_write_data_i  in  32  ALU result; used when the op is not a load.
- reg_write_addr_i  in  5  destination register.
- reg_write_en_i  in  1  destination write enable.
- flush_i  in  1  kills the instruction in this stage.
- bus_req  out  1  data request.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- bus_wstrb  out  4  byte strobes.
- bus_wdata  out  32  lane-replicated store data.
- bus_addr_ok  in  1  request accepted.
- bus_data_ok  in  1  response valid.
- bus_rdata  in  32  read data, little-endian.
- out_valid  out  1  one-cycle pulse to WB.
- reg_write_data_o  out  32  write-back data.
- reg_write_addr_o  out  5  write-back register.
- reg_write_en_o  out  1  write-back enable.
- addr_exc_o  out  1  misaligned-address exception; see Optional Feature.

Behaviour:
- Reset, synchronous and active-high, on the rising edge of clk:
  - state = IDLE; the kill flag and all captured registers are cleared.
  - out_valid, reg_write_*_o, addr_exc_o, bus_req, bus_we, bus_wstrb, bus_addr and bus_wdata are all 0.
- Reset mid-transaction:
  - The next cycle is IDLE with bus_req = 0.
  - No response is awaited; the bus slave shares rst.
- Acceptance: in_valid && in_ready captures every input.
- States:
  - IDLE, accept with op NONE: out_valid = 1 in the next cycle (latency 1), passing reg_write_*_i through. Stay in IDLE.
  - IDLE, accept with a memory op: go to REQ.
  - IDLE, accept while flush_i = 1: the instruction is dropped; no output.
  - REQ:
    - bus_req = 1, driven from registers.
    - bus_we/addr/wstrb/wdata stay stable until bus_addr_ok.
    - addr_ok && !data_ok: go to RESP.
    - addr_ok && data_ok in the same cycle: go to DONE.
    - bus_req is never dropped before addr_ok.
  - RESP: bus_req = 0; wait for bus_data_ok, then go to DONE and latch bus_rdata.
  - DONE: out_valid = 1 for one cycle (unless killed), then go to IDLE. in_ready = 0 in DONE.
- Load result, using byte offset a = addr[1:0]:
  - LB / LBU: byte a of bus_rdata, sign- or zero-extended.
  - LH / LHU: halfword a[1] of bus_rdata, sign- or zero-extended.
  - LW: bus_rdata unchanged.
  - reg_write_data_o is the extended value.
- Store result:
  - SB: wstrb = 4'b0001 << a; wdata = {4{data[7:0]}}.
  - SH: wstrb = 4'b0011 << {a[1],1'b0}; wdata = {2{data[15:0]}}.
  - SW: wstrb = 4'b1111.
  - Stores force reg_write_en_o = 0. out_valid still pulses.
- Loads: reg_write_en_o = captured reg_write_en_i.
- Flush in REQ/RESP/DONE:
  - Sets the kill flag. The bus transaction still runs to completion (no protocol violation).
  - The DONE pulse is suppressed: out_valid = 0, reg_write_en_o = 0.
- Outputs other than out_valid hold their last values when out_valid = 0. WB qualifies them with out_valid.

Optional Feature:
- Macro: MEM_ALIGN_EXC_EN.
- Defined:
  - Halfword ops with addr[0] != 0, or word ops with addr[1:0] != 0, make no bus access.
  - The stage goes IDLE -> DONE directly. out_valid = 1, addr_exc_o = 1, reg_write_en_o = 0.
- Undefined:
  - Offending low address bits are silently forced to 0 for size selection and strobes.
  - addr_exc_o is tied to 0.

Test Plan:
- Reset then an OR-result pass-through: rst held for 2 cycles -> all outputs 0. Then op NONE, data 0x0000_00FF, addr 5, en 1 -> out_valid, data 0x0000_00FF and addr 5 in the next cycle; in_ready stays 1.
- LB at 0x1000_0003 with rdata 0x80FF_1234: addr_ok at REQ cycle 2, data_ok 3 cycles later -> bus_addr = 0x1000_0000, data_o = 0xFFFF_FF80. in_ready stays 0 until the cycle after the DONE pulse. Repeat as LBU -> 0x0000_0080.
- SH at 0x2000_0002 with data 0xABCD_1234, addr_ok and data_ok in the same cycle -> wstrb = 4'b1100, wdata = 0x1234_1234, reg_write_en_o = 0, out_valid pulses once.
- flush_i asserted in RESP of an LW -> transaction completes on the bus; out_valid stays 0; the next instruction is accepted afterwards.
- LW at 0x0000_0006:
  - with MEM_ALIGN_EXC_EN: bus_req never asserted; addr_exc_o = 1.
  - without it: bus_addr = 0x0000_0004, normal load.
- rst asserted while in RESP -> next cycle is IDLE with bus_req = 0 and out_valid = 0. A fresh op NONE then completes with latency 1.

Source files
------------

// File: rtl/mem_access_if.sv
// Data-bus bundle between the memory-access stage (master) and the SoC data-bus slave.
interface mem_access_if #(
    parameter int DATA_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [DATA_W-1:0] bus_addr;
    logic [3:0]        bus_wstrb;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/mem_access.sv
// MIPS memory-access stage: at most one data-bus transaction per instruction, result pulsed to WB.
// Define MEM_ALIGN_EXC_EN to trap misaligned halfword/word accesses instead of truncating the address.
//
// state | meaning
// IDLE  | ready to accept; non-memory ops pass straight through with latency 1
// REQ   | bus_req held from registers until bus_addr_ok
// RESP  | request accepted, waiting for bus_data_ok
// DONE  | result presented on out_valid for one cycle (suppressed if killed)
module mem_access #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            mem_op_i,
    input  logic [DATA_W-1:0]     mem_addr_i,
    input  logic [DATA_W-1:0]     mem_store_data_i,
    input  logic [DATA_W-1:0]     reg_write_data_i,
    input  logic [REG_ADDR_W-1:0] reg_write_addr_i,
    input  logic                  reg_write_en_i,
    input  logic                  flush_i,
    mem_access_if.master          dbus,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     reg_write_data_o,
    output logic [REG_ADDR_W-1:0] reg_write_addr_o,
    output logic                  reg_write_en_o,
    output logic                  addr_exc_o
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

`ifdef MEM_ALIGN_EXC_EN
    localparam bit ALIGN_EXC = 1'b1;
`else
    localparam bit ALIGN_EXC = 1'b0;
`endif

    state_t                state;
    logic                  kill;
    logic                  valid_q;
    logic                  wen_q;
    logic [3:0]            op_q;
    logic [1:0]            off_q;
    logic [DATA_W-1:0]     alu_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  rd_en_q;

    logic                  accept;
    logic                  is_load;
    logic                  is_store;
    logic                  misalign;
    logic [3:0]            strb_n;
    logic [DATA_W-1:0]     wdata_n;
    logic                  load_q;
    logic [7:0]            rbyte;
    logic [15:0]           rhalf;
    logic [DATA_W-1:0]     load_val;
    logic                  fire;
    logic                  killed;
    logic                  done_flush;

    assign in_ready   = (state == IDLE);
    assign accept     = in_valid && in_ready;
    assign killed     = kill || flush_i;
    assign fire       = ((state == REQ) && dbus.bus_addr_ok && dbus.bus_data_ok) ||
                        ((state == RESP) && dbus.bus_data_ok);
    // A flush landing on the DONE cycle itself must still cancel the pulse.
    assign done_flush     = (state == DONE) && flush_i;
    assign out_valid      = valid_q && !done_flush;
    assign reg_write_en_o = wen_q && !done_flush;

    always_comb begin
        is_load  = (mem_op_i >= OP_LB) && (mem_op_i <= OP_LW);
        is_store = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
        misalign = 1'b0;
        strb_n   = 4'b0000;
        wdata_n  = '0;
        case (mem_op_i)
            OP_LH, OP_LHU: misalign = mem_addr_i[0];
            OP_LW:         misalign = |mem_addr_i[1:0];
            OP_SB: begin
                strb_n  = 4'b0001 << mem_addr_i[1:0];
                wdata_n = {4{mem_store_data_i[7:0]}};
            end
            OP_SH: begin
                misalign = mem_addr_i[0];
                strb_n   = 4'b0011 << {mem_addr_i[1], 1'b0};
                wdata_n  = {2{mem_store_data_i[15:0]}};
            end
            OP_SW: begin
                misalign = |mem_addr_i[1:0];
                strb_n   = 4'b1111;
                wdata_n  = mem_store_data_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        load_q = (op_q >= OP_LB) && (op_q <= OP_LW);
        rbyte  = dbus.bus_rdata[7:0];
        case (off_q)
            2'd1:    rbyte = dbus.bus_rdata[15:8];
            2'd2:    rbyte = dbus.bus_rdata[23:16];
            2'd3:    rbyte = dbus.bus_rdata[31:24];
            default: rbyte = dbus.bus_rdata[7:0];
        endcase
        rhalf    = off_q[1] ? dbus.bus_rdata[31:16] : dbus.bus_rdata[15:0];
        load_val = dbus.bus_rdata;
        case (op_q)
            OP_LB:   load_val = {{24{rbyte[7]}}, rbyte};
            OP_LBU:  load_val = {24'h0, rbyte};
            OP_LH:   load_val = {{16{rhalf[15]}}, rhalf};
            OP_LHU:  load_val = {16'h0, rhalf};
            default: load_val = dbus.bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            kill             <= 1'b0;
            valid_q          <= 1'b0;
            wen_q            <= 1'b0;
            op_q             <= '0;
            off_q            <= '0;
            alu_q            <= '0;
            rd_q             <= '0;
            rd_en_q          <= 1'b0;
            reg_write_data_o <= '0;
            reg_write_addr_o <= '0;
            addr_exc_o       <= 1'b0;
            dbus.bus_req     <= 1'b0;
            dbus.bus_we      <= 1'b0;
            dbus.bus_addr    <= '0;
            dbus.bus_wstrb   <= '0;
            dbus.bus_wdata   <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && !flush_i) begin
                        op_q    <= mem_op_i;
                        off_q   <= mem_addr_i[1:0];
                        alu_q   <= reg_write_data_i;
                        rd_q    <= reg_write_addr_i;
                        rd_en_q <= reg_write_en_i;
                        kill    <= 1'b0;
                        if (ALIGN_EXC && misalign) begin
                            state            <= DONE;
                            valid_q          <= 1'b1;
                            addr_exc_o       <= 1'b1;
                            wen_q            <= 1'b0;
                            reg_write_data_o <= reg_write_data_i;
                            reg_write_addr_o <= reg_write_addr_i;
                        end else if (is_load || is_store) begin
                            state          <= REQ;
                            dbus.bus_req   <= 1'b1;
                            dbus.bus_we    <= is_store;
                            dbus.bus_addr  <= {mem_addr_i[DATA_W-1:2], 2'b00};
                            dbus.bus_wstrb <= strb_n;
                            dbus.bus_wdata <= wdata_n;
                        end else begin
                            valid_q          <= 1'b1;
                            addr_exc_o       <= 1'b0;
                            wen_q            <= reg_write_en_i;
                            reg_write_data_o <= reg_write_data_i;
                            reg_write_addr_o <= reg_write_addr_i;
                        end
                    end
                end
                REQ: begin
                    if (flush_i) kill <= 1'b1;
                    if (dbus.bus_addr_ok) begin
                        dbus.bus_req <= 1'b0;
                        state        <= dbus.bus_data_ok ? DONE : RESP;
                    end
                end
                RESP: begin
                    if (flush_i) kill <= 1'b1;
                    if (dbus.bus_data_ok) state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                    kill  <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            if (fire) begin
                valid_q    <= !killed;
                addr_exc_o <= 1'b0;
                if (killed) begin
                    wen_q <= 1'b0;
                end else begin
                    reg_write_data_o <= load_q ? load_val : alu_q;
                    reg_write_addr_o <= rd_q;
                    wen_q            <= load_q && rd_en_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed plan vectors plus random ops against a reference model.
module tb_mem_access;

`ifdef MEM_ALIGN_EXC_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  mem_op_i = '0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_store_data_i = '0;
    logic [31:0] reg_write_data_i = '0;
    logic [4:0]  reg_write_addr_i = '0;
    logic        reg_write_en_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        out_valid;
    logic [31:0] reg_write_data_o;
    logic [4:0]  reg_write_addr_o;
    logic        reg_write_en_o;
    logic        addr_exc_o;

    mem_access_if #(.DATA_W(32)) dbus ();

    mem_access #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .mem_op_i         (mem_op_i),
        .mem_addr_i       (mem_addr_i),
        .mem_store_data_i (mem_store_data_i),
        .reg_write_data_i (reg_write_data_i),
        .reg_write_addr_i (reg_write_addr_i),
        .reg_write_en_i   (reg_write_en_i),
        .flush_i          (flush_i),
        .dbus             (dbus),
        .out_valid        (out_valid),
        .reg_write_data_o (reg_write_data_o),
        .reg_write_addr_o (reg_write_addr_o),
        .reg_write_en_o   (reg_write_en_o),
        .addr_exc_o       (addr_exc_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Bus slave: grants after addr_lat request cycles, responds data_lat cycles later.
    int          addr_lat = 1;
    int          data_lat = 0;
    logic [31:0] resp_rdata = '0;
    int          acc_cnt = 0;
    int          cmpl_cnt = 0;
    bit          pend = 0;
    int          dcnt = 0;
    int          req_cnt = 0;
    bit          stab_err = 0;
    logic        snap_we;
    logic [31:0] snap_addr;
    logic [3:0]  snap_wstrb;
    logic [31:0] snap_wdata;

    always @(negedge clk) begin
        dbus.bus_addr_ok = 1'b0;
        dbus.bus_data_ok = 1'b0;
        dbus.bus_rdata   = $urandom;
        if (rst) begin
            pend    = 0;
            req_cnt = 0;
        end else if (pend) begin
            if (dcnt == 0) begin
                dbus.bus_data_ok = 1'b1;
                dbus.bus_rdata   = resp_rdata;
                pend             = 0;
                cmpl_cnt++;
            end else begin
                dcnt--;
            end
        end else if (dbus.bus_req) begin
            req_cnt++;
            if (req_cnt == 1) begin
                snap_we    = dbus.bus_we;
                snap_addr  = dbus.bus_addr;
                snap_wstrb = dbus.bus_wstrb;
                snap_wdata = dbus.bus_wdata;
            end else if ({snap_we, snap_addr, snap_wstrb, snap_wdata} !==
                         {dbus.bus_we, dbus.bus_addr, dbus.bus_wstrb, dbus.bus_wdata}) begin
                stab_err = 1;
            end
            if (req_cnt >= addr_lat) begin
                acc_cnt++;
                req_cnt          = 0;
                dbus.bus_addr_ok = 1'b1;
                if (data_lat == 0) begin
                    dbus.bus_data_ok = 1'b1;
                    dbus.bus_rdata   = resp_rdata;
                    cmpl_cnt++;
                end else begin
                    pend = 1;
                    dcnt = data_lat - 1;
                end
            end
        end
    end

    // Reference model, straight from the load/store rules.
    function automatic bit op_is_load(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd5);
    endfunction

    function automatic bit op_is_store(input logic [3:0] op);
        return (op >= 4'd6) && (op <= 4'd8);
    endfunction

    function automatic bit op_misaligned(input logic [3:0] op, input logic [31:0] addr);
        if ((op == 4'd3 || op == 4'd4 || op == 4'd7) && (addr % 2 != 0)) return 1;
        if ((op == 4'd5 || op == 4'd8) && (addr % 4 != 0)) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] addr,
                                               input logic [31:0] rd);
        int unsigned b;
        int unsigned h;
        b = (rd >> (8 * (addr % 4))) % 256;
        h = (rd >> (16 * ((addr % 4) / 2))) % 65536;
        case (op)
            4'd1:    return (b >= 128) ? b - 256 : b;
            4'd2:    return b;
            4'd3:    return (h >= 32768) ? h - 65536 : h;
            4'd4:    return h;
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] model_strb(input logic [3:0] op, input logic [31:0] addr);
        case (op)
            4'd6:    return 4'(1 << (addr % 4));
            4'd7:    return 4'(3 << (2 * ((addr % 4) / 2)));
            4'd8:    return 4'd15;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [3:0] op, input logic [31:0] d);
        case (op)
            4'd6:    return (d % 256) * 32'h0101_0101;
            4'd7:    return (d % 65536) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [31:0] rwd, input logic [4:0] ra, input logic en,
                         input logic fl);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("issue_ready", in_ready, 1);
        in_valid         = 1'b1;
        mem_op_i         = op;
        mem_addr_i       = addr;
        mem_store_data_i = sd;
        reg_write_data_i = rwd;
        reg_write_addr_i = ra;
        reg_write_en_i   = en;
        flush_i          = fl;
        @(negedge clk);
        in_valid         = 1'b0;
        flush_i          = 1'b0;
        mem_op_i         = 4'($urandom);
        mem_addr_i       = $urandom;
        mem_store_data_i = $urandom;
        reg_write_data_i = $urandom;
        reg_write_addr_i = 5'($urandom);
        reg_write_en_i   = 1'($urandom);
    endtask

    task automatic wait_pulse(input int budget, output bit got, output int cyc, output bit rdy_seen);
        got      = 0;
        cyc      = 0;
        rdy_seen = 0;
        while (!got && cyc < budget) begin
            if (out_valid) begin
                got = 1;
            end else begin
                if (in_ready) rdy_seen = 1;
                @(negedge clk);
                cyc++;
            end
        end
    endtask

    task automatic run_check(input string tag, input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] sd, input logic [31:0] rwd, input logic [4:0] ra,
                             input logic en, input int al, input int dl, input logic [31:0] rdat);
        bit got;
        bit rdy_seen;
        bit mem;
        bit exc;
        int cyc;
        int acc0;
        addr_lat   = al;
        data_lat   = dl;
        resp_rdata = rdat;
        stab_err   = 0;
        mem  = op_is_load(op) || op_is_store(op);
        exc  = ALIGN && mem && op_misaligned(op, addr);
        acc0 = acc_cnt;
        issue(op, addr, sd, rwd, ra, en, 1'b0);
        wait_pulse(40, got, cyc, rdy_seen);
        chk({tag, "_pulse"}, got, 1);
        if (got) begin
            chk({tag, "_wb_addr"}, reg_write_addr_o, ra);
            chk({tag, "_exc"}, addr_exc_o, exc);
            if (exc) begin
                chk({tag, "_wb_en"}, reg_write_en_o, 0);
            end else if (op_is_load(op)) begin
                chk({tag, "_wb_data"}, reg_write_data_o, model_load(op, addr, rdat));
                chk({tag, "_wb_en"}, reg_write_en_o, en);
            end else if (op_is_store(op)) begin
                chk({tag, "_wb_en"}, reg_write_en_o, 0);
            end else begin
                chk({tag, "_wb_data"}, reg_write_data_o, rwd);
                chk({tag, "_wb_en"}, reg_write_en_o, en);
                chk({tag, "_latency"}, cyc, 0);
            end
            chk({tag, "_ready_at_pulse"}, in_ready, !mem);
            if (mem) chk({tag, "_ready_while_busy"}, rdy_seen, 0);
            if (mem && !exc) begin
                chk({tag, "_bus_txn"}, acc_cnt - acc0, 1);
                chk({tag, "_bus_addr"}, snap_addr, addr - (addr % 4));
                chk({tag, "_bus_we"}, snap_we, op_is_store(op));
                chk({tag, "_bus_stable"}, stab_err, 0);
                if (op_is_store(op)) begin
                    chk({tag, "_wstrb"}, snap_wstrb, model_strb(op, addr));
                    chk({tag, "_wdata"}, snap_wdata, model_wdata(op, sd));
                end
            end else begin
                chk({tag, "_no_bus"}, acc_cnt - acc0, 0);
            end
            @(negedge clk);
            chk({tag, "_one_pulse"}, out_valid, 0);
            chk({tag, "_ready_after"}, in_ready, 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit got;
        bit rdy_seen;
        int cyc;
        int n;
        int acc0;
        int cm0;

        // Reset held two cycles
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_wb_data", reg_write_data_o, 0);
        chk("rst_wb_addr", reg_write_addr_o, 0);
        chk("rst_wb_en", reg_write_en_o, 0);
        chk("rst_exc", addr_exc_o, 0);
        chk("rst_bus_req", dbus.bus_req, 0);
        chk("rst_bus_we", dbus.bus_we, 0);
        chk("rst_bus_addr", dbus.bus_addr, 0);
        chk("rst_bus_wstrb", dbus.bus_wstrb, 0);
        chk("rst_bus_wdata", dbus.bus_wdata, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        run_check("none_pass", 4'd0, 32'h0, 32'h0, 32'h0000_00FF, 5'd5, 1'b1, 1, 0, 32'h0);
        run_check("lb_neg", 4'd1, 32'h1000_0003, 32'h0, 32'h0, 5'd9, 1'b1, 2, 3, 32'h80FF_1234);
        run_check("lbu", 4'd2, 32'h1000_0003, 32'h0, 32'h0, 5'd9, 1'b1, 2, 3, 32'h80FF_1234);
        run_check("sh_same", 4'd7, 32'h2000_0002, 32'hABCD_1234, 32'h55, 5'd3, 1'b1, 1, 0, 32'h0);
        run_check("lw_mis", 4'd5, 32'h0000_0006, 32'h0, 32'h0, 5'd7, 1'b1, 1, 1, 32'hCAFE_F00D);
        run_check("op_hi", 4'd12, 32'h0000_0003, 32'h0, 32'h1234_5678, 5'd30, 1'b1, 1, 0, 32'h0);

        // Flush on accept drops the instruction
        issue(4'd0, 32'h0, 32'h0, 32'hDEAD_BEEF, 5'd1, 1'b1, 1'b1);
        wait_pulse(5, got, cyc, rdy_seen);
        chk("flush_accept_no_pulse", got, 0);

        // Flush in RESP: bus completes, pulse suppressed
        acc0       = acc_cnt;
        cm0        = cmpl_cnt;
        addr_lat   = 1;
        data_lat   = 6;
        resp_rdata = 32'h1111_2222;
        issue(4'd5, 32'h0000_0040, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0);
        n = 0;
        while (acc_cnt == acc0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("flush_addr_ok", acc_cnt - acc0, 1);
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        wait_pulse(15, got, cyc, rdy_seen);
        chk("flush_resp_no_pulse", got, 0);
        chk("flush_bus_complete", cmpl_cnt - cm0, 1);
        chk("flush_wb_en", reg_write_en_o, 0);
        chk("flush_ready", in_ready, 1);
        run_check("after_flush", 4'd0, 32'h0, 32'h0, 32'h0BAD_F00D, 5'd12, 1'b1, 1, 0, 32'h0);

        // Reset while in RESP
        acc0       = acc_cnt;
        addr_lat   = 1;
        data_lat   = 10;
        resp_rdata = 32'h7777_8888;
        issue(4'd5, 32'h0000_0080, 32'h0, 32'h0, 5'd6, 1'b1, 1'b0);
        n = 0;
        while (acc_cnt == acc0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rstmid_addr_ok", acc_cnt - acc0, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_bus_req", dbus.bus_req, 0);
        chk("rstmid_out_valid", out_valid, 0);
        chk("rstmid_in_ready", in_ready, 1);
        chk("rstmid_wb_data", reg_write_data_o, 0);
        run_check("rstmid_none", 4'd0, 32'h0, 32'h0, 32'hA5A5_5A5A, 5'd17, 1'b1, 1, 0, 32'h0);

        for (int i = 0; i < 60; i++) begin
            run_check($sformatf("rand%0d", i), 4'($urandom_range(0, 15)), $urandom, $urandom,
                      $urandom, 5'($urandom), 1'($urandom), $urandom_range(1, 3),
                      $urandom_range(0, 3), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
